fifo_ctrl: RTL and testbench

Control and pointer logic that turns the dual-port `memoria` block into a synchronous FIFO. It drives the memory's write side (`write`, `addressW`, `data_in`) and read side (`read`, `addressR`), and returns `data_out` to the consumer with a valid strobe. It also maintains occupancy, full/empty and error status. `fifo_ctrl` plus one `memoria` instance form the FIFO used by the upstream and downstream blocks of the design.

---
 rtl/fifo_ctrl_pkg.sv | 11 +
 rtl/fifo_ctrl_ptr.sv | 16 +
 rtl/fifo_ctrl.sv | 72 +++++++
 tb/tb_fifo_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// fifo_defs: shared FIFO geometry defaults and derived sizes.
package fifo_defs;
  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_BUS_SIZE = 32;
  function automatic int mem_length(input int aw);
    return 1 << aw;
  endfunction
  function automatic int count_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/fifo_ctrl_ptr.sv
// fifo_ptr: wrapping W-bit pointer with increment enable and async active-low reset.
module fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = inc_i ? ptr_q + W'(1) : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status control that turns memoria into a synchronous FIFO.
// Optional almost_full/almost_empty thresholds are enabled by defining FIFO_THRESH_EN.
import fifo_defs::*;
module fifo_ctrl #(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int BUS_SIZE = FIFO_BUS_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic [BUS_SIZE-1:0]   push_data,
  input  logic                  pop,
  output logic [BUS_SIZE-1:0]   pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  error,
  output logic                  almost_full,
  output logic                  almost_empty,
  input  logic [ADDR_WIDTH-1:0] thresh_af,
  input  logic [ADDR_WIDTH-1:0] thresh_ae,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addressW,
  output logic [ADDR_WIDTH-1:0] mem_addressR,
  output logic [BUS_SIZE-1:0]   mem_data_in,
  input  logic [BUS_SIZE-1:0]   mem_data_out
);
  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(mem_length(ADDR_WIDTH));
  logic [CW-1:0] count_q, count_d;
  logic pop_valid_q, error_q, error_d;
  logic push_ok, pop_ok;
  // Status comes from registered count only, so a same-cycle pop never frees a slot for push (and vice versa).
  always_comb begin
    full = count_q == FULL_CNT;
    empty = count_q == '0;
    push_ok = push & ~full;
    pop_ok = pop & ~empty;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    error_d = error_q | (push & full) | (pop & empty);
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      count_q <= '0;
      pop_valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pop_valid_q <= pop_ok;
      error_q <= error_d;
    end
  fifo_ptr #(.W(ADDR_WIDTH)) u_wr_ptr (.clk(clk), .rst_n(reset_L), .inc_i(push_ok), .ptr_o(mem_addressW));
  fifo_ptr #(.W(ADDR_WIDTH)) u_rd_ptr (.clk(clk), .rst_n(reset_L), .inc_i(pop_ok), .ptr_o(mem_addressR));
  assign mem_write = push_ok & reset_L;
  assign mem_read = pop_ok & reset_L;
  assign mem_data_in = push_data;
  assign pop_data = mem_data_out;
  assign pop_valid = pop_valid_q;
  assign count = count_q;
  assign error = error_q;
`ifdef FIFO_THRESH_EN
  assign almost_full = count_q >= FULL_CNT - {1'b0, thresh_af};
  assign almost_empty = count_q <= {1'b0, thresh_ae};
`else
  logic unused_thresh;
  assign unused_thresh = ^{thresh_af, thresh_ae};
  assign almost_full = 1'b0;
  assign almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized scoreboard bench for fifo_ctrl with a behavioural memoria and queue model.
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic reset_L;
  logic push, pop;
  logic [31:0] push_data, pop_data, mem_data_in;
  logic pop_valid, full, empty, error, almost_full, almost_empty;
  logic [4:0] count;
  logic [3:0] thresh_af, thresh_ae, mem_addressW, mem_addressR;
  logic mem_write, mem_read;
  logic [31:0] mem_data_out;
  logic [31:0] mem [16];

  int total = 0;
  int passed = 0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  int wr = 0, rd = 0;
  bit err_m = 0;
  bit vexp = 0;

  fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty), .count(count),
    .error(error), .almost_full(almost_full), .almost_empty(almost_empty),
    .thresh_af(thresh_af), .thresh_ae(thresh_ae), .mem_write(mem_write), .mem_read(mem_read),
    .mem_addressW(mem_addressW), .mem_addressR(mem_addressR), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addressW] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addressR];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    else passed++;
  endtask

  function automatic bit af_model(input int c);
`ifdef FIFO_THRESH_EN
    return c >= 16 - int'(thresh_af);
`else
    return c < 0;
`endif
  endfunction

  function automatic bit ae_model(input int c);
`ifdef FIFO_THRESH_EN
    return c <= int'(thresh_ae);
`else
    return c < 0;
`endif
  endfunction

  task automatic check_status();
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == 16));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("error", 32'(error), 32'(err_m));
    chk("pop_valid", 32'(pop_valid), 32'(vexp));
    chk("almost_full", 32'(almost_full), 32'(af_model(mq.size())));
    chk("almost_empty", 32'(almost_empty), 32'(ae_model(mq.size())));
  endtask

  // Scoreboard monitor: every valid word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    if (reset_L && pop_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL pop_data: unexpected valid word %h at %0t", pop_data, $time);
      end else chk("pop_data", pop_data, exp_q.pop_front());
    end
  end

  task automatic step(input logic p, input logic [31:0] d, input logic q);
    bit pa, qa;
    push = p;
    push_data = d;
    pop = q;
    #1;
    pa = p && mq.size() < 16;
    qa = q && mq.size() > 0;
    chk("mem_write", 32'(mem_write), 32'(pa));
    chk("mem_read", 32'(mem_read), 32'(qa));
    chk("addressW", 32'(mem_addressW), 32'(wr));
    chk("addressR", 32'(mem_addressR), 32'(rd));
    chk("data_in", mem_data_in, d);
    if (qa) begin
      exp_q.push_back(mq.pop_front());
      rd = (rd + 1) % 16;
    end
    if (pa) begin
      mq.push_back(d);
      wr = (wr + 1) % 16;
    end
    if ((p && !pa) || (q && !qa)) err_m = 1;
    vexp = qa;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic reset_midrun();
    push = 1'b1;
    pop = 1'b1;
    reset_L = 1'b0;
    #1;
    mq.delete();
    exp_q.delete();
    wr = 0;
    rd = 0;
    err_m = 0;
    vexp = 0;
    check_status();
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_addressW", 32'(mem_addressW), 32'd0);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    push_data = '0;
    thresh_af = 4'd2;
    thresh_ae = 4'd3;
    #1;
    check_status();
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    check_status();
    for (int i = 0; i < 16; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h5, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 55, $urandom, r >= 35);
    end
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0);
    reset_midrun();
    for (int i = 0; i < 100; i++) step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
    while (mq.size() > 0) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
